tremolo_lfo_ctrl: RTL and testbench

- Sequencer for the tremolo shift datapath. It owns a sample-rate LFO that steps the 3-bit attenuation index (shift amount 0..7) up and down in a triangle between 0 and a programmable depth.
- It applies the index to each incoming audio sample and registers the result with a valid strobe.
- It sits between the sample source (ADC/codec deserialiser) and the next effect stage, one sample per sample_valid strobe.

---
 rtl/tremolo_lfo_ctrl_pkg.sv | 13 +
 rtl/tremolo_lfo_ctrl_table.sv | 21 ++
 rtl/tremolo_lfo_ctrl.sv | 116 +++++++++++
 tb/tb_tremolo_lfo_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tremolo_lfo_ctrl_pkg.sv
// Shared definitions for the tremolo LFO controller: LFO state encoding,
// index width and maximum depth.
package tremolo_lfo_ctrl_pkg;

  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] MAX_DEPTH = 3'd7;

  typedef enum logic {
    RISE = 1'b0,
    FALL = 1'b1
  } lfo_state_e;

endpackage

// File: rtl/tremolo_lfo_ctrl_table.sv
// Combinational shift datapath: arithmetic right shift of the sample by the
// LFO index when enabled, straight pass-through when bypassed.
module tremolo_table
  import tremolo_lfo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [IDX_W-1:0]      counter,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y
);

  logic signed [DATA_WIDTH-1:0] x_s;

  always_comb begin
    x_s = $signed(x);
    y   = en ? $unsigned(x_s >>> counter) : x;
  end

endmodule

// File: rtl/tremolo_lfo_ctrl.sv
// Tremolo sequencer: sample-rate prescaler plus triangle LFO driving the
// shift index of tremolo_table. Square wave mode is enabled by TREMOLO_SQUARE_EN.
module tremolo_lfo_ctrl
  import tremolo_lfo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RATE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [RATE_WIDTH-1:0] rate,
  input  logic [2:0]            depth,
`ifdef TREMOLO_SQUARE_EN
  input  logic                  wave_sel,
`endif
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  y_valid,
  output logic [2:0]            lfo_idx
);

  lfo_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [RATE_WIDTH-1:0] presc_q, presc_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic                  y_valid_q, y_valid_d;
  logic [DATA_WIDTH-1:0] shifted;
  logic [RATE_WIDTH-1:0] rate_m1;
  logic                  step;
  logic                  square;

`ifdef TREMOLO_SQUARE_EN
  assign square = wave_sel;
`else
  assign square = 1'b0;
`endif

  tremolo_table #(.DATA_WIDTH(DATA_WIDTH)) u_table (
    .counter (idx_q),
    .en      (en),
    .x       (x_in),
    .y       (shifted)
  );

  always_comb begin
    rate_m1 = (rate == '0) ? '0 : rate - 1'b1;
    // >= so that a rate lowered below the running count steps on the next strobe
    step    = en && sample_valid && (presc_q >= rate_m1);

    y_d       = y_q;
    y_valid_d = sample_valid;
    if (sample_valid) y_d = shifted;

    presc_d = presc_q;
    if (en && sample_valid) presc_d = step ? '0 : presc_q + 1'b1;

    idx_d   = idx_q;
    state_d = state_q;
    if (!en || depth == '0) begin
      idx_d   = '0;
      state_d = RISE;
      if (!en) presc_d = '0;
    end else if (idx_q > depth) begin
      // Depth lowered under the index: clamp immediately and head back down
      idx_d   = depth;
      state_d = FALL;
    end else if (step) begin
      if (square) begin
        if (state_q == RISE) begin
          idx_d   = depth;
          state_d = FALL;
        end else begin
          idx_d   = '0;
          state_d = RISE;
        end
      end else if (state_q == RISE) begin
        if (idx_q < depth) begin
          idx_d = idx_q + 1'b1;
          if (idx_q + 1'b1 == depth) state_d = FALL;
        end else begin
          state_d = FALL;
        end
      end else begin
        if (idx_q > '0) begin
          idx_d = idx_q - 1'b1;
          if (idx_q == 3'd1) state_d = RISE;
        end else begin
          state_d = RISE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RISE;
      idx_q     <= '0;
      presc_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      presc_q   <= presc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_out   = y_q;
  assign y_valid = y_valid_q;
  assign lfo_idx = idx_q;

endmodule

// File: tb/tb_tremolo_lfo_ctrl.sv
// Directed vector bench for tremolo_lfo_ctrl: table of per-cycle vectors plus
// hand sequences for reset-with-strobe and (with TREMOLO_SQUARE_EN) square mode.
module tb_tremolo_lfo_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sample_valid;
  logic [31:0] x_in;
  logic [15:0] rate;
  logic [2:0]  depth;
  logic        wave_sel;
  logic [31:0] y_out;
  logic        y_valid;
  logic [2:0]  lfo_idx;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        rst;
    logic        en;
    logic        sv;
    logic [31:0] x;
    logic [15:0] rate;
    logic [2:0]  depth;
    logic [31:0] ey;
    logic        eyv;
    logic [2:0]  eidx;
  } vec_t;

  vec_t vecs[$];

  tremolo_lfo_ctrl #(.DATA_WIDTH(32), .RATE_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_valid (sample_valid),
    .x_in         (x_in),
    .rate         (rate),
    .depth        (depth),
`ifdef TREMOLO_SQUARE_EN
    .wave_sel     (wave_sel),
`endif
    .y_out        (y_out),
    .y_valid      (y_valid),
    .lfo_idx      (lfo_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic sv, input logic [31:0] x,
                     input logic [15:0] rt, input logic [2:0] d,
                     input logic [31:0] ey, input logic eyv, input logic [2:0] eidx);
    vec_t v;
    v.rst = r; v.en = e; v.sv = sv; v.x = x; v.rate = rt; v.depth = d;
    v.ey = ey; v.eyv = eyv; v.eidx = eidx;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_step(input logic r, input logic e, input logic sv, input logic [31:0] x,
                            input logic [15:0] rt, input logic [2:0] d);
    rst = r; en = e; sample_valid = sv; x_in = x; rate = rt; depth = d;
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  pre_idx [9];
  logic [31:0] pre_y   [9];

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; en = 1'b0; sample_valid = 1'b0; x_in = '0; rate = 16'd1; depth = 3'd0;
    wave_sel = 1'b0;

    // reset, reset overriding a strobe, bypass
    add(1, 0, 0, 32'h0,         1, 3, 32'h0,         0, 0);
    add(1, 0, 1, 32'h1234,      1, 3, 32'h0,         0, 0);
    add(0, 0, 1, 32'h0000_4000, 1, 3, 32'h0000_4000, 1, 0);
    add(0, 0, 0, 32'h0000_4000, 1, 3, 32'h0000_4000, 0, 0);
    // triangle sweep, rate=1, depth=3
    add(0, 1, 1, 32'h800, 1, 3, 32'h800, 1, 1);
    add(0, 1, 1, 32'h800, 1, 3, 32'h400, 1, 2);
    add(0, 1, 1, 32'h800, 1, 3, 32'h200, 1, 3);
    add(0, 1, 1, 32'h800, 1, 3, 32'h100, 1, 2);
    add(0, 1, 1, 32'h800, 1, 3, 32'h200, 1, 1);
    add(0, 1, 1, 32'h800, 1, 3, 32'h400, 1, 0);
    add(0, 1, 1, 32'h800, 1, 3, 32'h800, 1, 1);
    add(0, 1, 0, 32'h800, 1, 3, 32'h800, 0, 1);
    add(0, 1, 1, 32'h800, 1, 3, 32'h400, 1, 2);
    // negative sample at idx 2
    add(0, 1, 1, 32'hFFFF_F000, 1, 3, 32'hFFFF_FC00, 1, 3);
    // disable clears the LFO
    add(0, 0, 1, 32'h100, 1, 3, 32'h100, 1, 0);
    // prescaler: rate=4, depth=2, strobe every 3 cycles
    pre_idx = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2};
    pre_y   = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h200,
                32'h200, 32'h200, 32'h200, 32'h100};
    for (int k = 0; k < 9; k++) begin
      add(0, 1, 1, 32'h400, 4, 2, pre_y[k], 1, pre_idx[k]);
      add(0, 1, 0, 32'h400, 4, 2, pre_y[k], 0, pre_idx[k]);
      add(0, 1, 0, 32'h400, 4, 2, pre_y[k], 0, pre_idx[k]);
    end
    add(0, 0, 0, 32'h400, 4, 2, 32'h100, 0, 0);
    // rate=0 behaves as 1; climb to 5 with depth 7, then clamp to 2
    add(0, 1, 1, 32'h1000, 0, 7, 32'h1000, 1, 1);
    add(0, 1, 1, 32'h1000, 0, 7, 32'h0800, 1, 2);
    add(0, 1, 1, 32'h1000, 0, 7, 32'h0400, 1, 3);
    add(0, 1, 1, 32'h1000, 0, 7, 32'h0200, 1, 4);
    add(0, 1, 1, 32'h1000, 0, 7, 32'h0100, 1, 5);
    add(0, 1, 0, 32'h1000, 0, 2, 32'h0100, 0, 2);
    add(0, 1, 1, 32'h1000, 0, 2, 32'h0400, 1, 1);
    add(0, 1, 1, 32'h1000, 0, 2, 32'h0800, 1, 0);
    add(0, 1, 1, 32'h1000, 0, 2, 32'h1000, 1, 1);
    add(0, 1, 1, 32'h1000, 0, 2, 32'h0800, 1, 2);
    // depth=0: index forced to 0, sample passes unshifted
    add(0, 1, 0, 32'h1000, 0, 0, 32'h0800, 0, 0);
    add(0, 1, 1, 32'h1000, 0, 0, 32'h1000, 1, 0);
    add(0, 1, 1, 32'h1000, 0, 0, 32'h1000, 1, 0);
    add(0, 1, 1, 32'h1000, 1, 3, 32'h1000, 1, 1);

    foreach (vecs[i]) begin
      drive_step(vecs[i].rst, vecs[i].en, vecs[i].sv, vecs[i].x, vecs[i].rate, vecs[i].depth);
      chk($sformatf("vec%0d y_out", i),   y_out,           vecs[i].ey);
      chk($sformatf("vec%0d y_valid", i), {31'b0, y_valid}, {31'b0, vecs[i].eyv});
      chk($sformatf("vec%0d lfo_idx", i), {29'b0, lfo_idx}, {29'b0, vecs[i].eidx});
    end

    // reset together with a strobe mid-run: no stray output, LFO cleared
    drive_step(0, 1, 1, 32'h1000, 1, 3);
    chk("midrun pre idx", {29'b0, lfo_idx}, 32'd2);
    drive_step(1, 1, 1, 32'h1000, 1, 3);
    chk("rst+sv y_valid", {31'b0, y_valid}, 32'd0);
    chk("rst+sv lfo_idx", {29'b0, lfo_idx}, 32'd0);
    chk("rst+sv y_out",   y_out,            32'd0);
    drive_step(0, 1, 0, 32'h1000, 1, 3);
    chk("post rst y_valid", {31'b0, y_valid}, 32'd0);

`ifdef TREMOLO_SQUARE_EN
    wave_sel = 1'b1;
    drive_step(0, 1, 1, 32'h1000, 1, 4);
    chk("sq0 y", y_out, 32'h1000);
    chk("sq0 idx", {29'b0, lfo_idx}, 32'd4);
    drive_step(0, 1, 1, 32'h1000, 1, 4);
    chk("sq1 y", y_out, 32'h0100);
    chk("sq1 idx", {29'b0, lfo_idx}, 32'd0);
    drive_step(0, 1, 1, 32'h1000, 1, 4);
    chk("sq2 idx", {29'b0, lfo_idx}, 32'd4);
    drive_step(1, 1, 1, 32'h1000, 1, 4);
    chk("sq rst y_valid", {31'b0, y_valid}, 32'd0);
    chk("sq rst idx", {29'b0, lfo_idx}, 32'd0);
    wave_sel = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
